// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit -- fetch stage of the SEQ Y86-64 datapath.
//
// Holds the architectural PC and reads the current instruction one byte per
// memory handshake. It splits the bytes into icode/ifun/rA/rB/valC and
// computes the fall-through address valP.
//
// Optional feature macro: FETCH_INVALID_TRAP_EN. When it is defined, an
// illegal icode (C-F) also sets the sticky halted flag.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start               begin a fetch at PC (IDLE only, ignored when halted)
//   pc_load, next_pc    load PC from pc_update (IDLE and DONE only)
//   mem_req, mem_addr   byte read request and address (PC + byte index)
//   mem_data, mem_ack   read byte and acceptance strobe
//   mem_err             out-of-range fault, qualified by mem_ack
//   out_valid           decoded fields below are valid
//   pc                  current PC
//   icode, ifun, rA, rB decoded instruction fields
//   valC, valP          constant word and fall-through address
//   imem_error          memory fault during this fetch
//   instr_valid         icode is legal
//   halted              sticky halt/fault flag, cleared only by rst
//
// The first request is raised one cycle after start is taken, so with ack
// always high out_valid rises L+1 cycles after the start edge.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pc_load,
    input  logic [63:0] next_pc,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic [7:0]  mem_data,
    input  logic        mem_ack,
    input  logic        mem_err,
    output logic        out_valid,
    output logic [63:0] pc,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        imem_error,
    output logic        instr_valid,
    output logic        halted
);

    typedef enum logic [2:0] {IDLE, BYTE0, REGS, CONST, DONE} state_t;

    state_t      state, state_d;
    logic [3:0]  idx, idx_d;     // byte index within the instruction
    logic [3:0]  len, len_d;     // instruction length L
    logic [63:0] pc_d, mem_addr_d, valC_d, valP_d;
    logic [3:0]  icode_d, ifun_d, rA_d, rB_d;
    logic        mem_req_d, out_valid_d, imem_error_d, instr_valid_d, halted_d;
    logic        last_byte;

    // Instruction length from icode; illegal codes C-F behave as 1 byte.
    function automatic logic [3:0] instr_len(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
            4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
            4'h7, 4'h8:             instr_len = 4'd9;
            default:                instr_len = 4'd1;
        endcase
    endfunction

    // NOTE: every signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state;
        idx_d         = idx;
        len_d         = len;
        pc_d          = pc;
        mem_req_d     = mem_req;
        mem_addr_d    = mem_addr;
        out_valid_d   = out_valid;
        icode_d       = icode;
        ifun_d        = ifun;
        rA_d          = rA;
        rB_d          = rB;
        valC_d        = valC;
        valP_d        = valP;
        imem_error_d  = imem_error;
        instr_valid_d = instr_valid;
        halted_d      = halted;
        last_byte     = 1'b0;

        unique case (state)
            IDLE: begin
                if (pc_load) pc_d = next_pc;
                if (start && !halted) begin
                    // Fields absent from the instruction must read as F/F/0.
                    state_d       = BYTE0;
                    idx_d         = 4'd0;
                    icode_d       = 4'h0;
                    ifun_d        = 4'h0;
                    rA_d          = 4'hF;
                    rB_d          = 4'hF;
                    valC_d        = 64'h0;
                    valP_d        = 64'h0;
                    imem_error_d  = 1'b0;
                    instr_valid_d = 1'b0;
                end
            end

            BYTE0, REGS, CONST: begin
                if (!mem_req) begin
                    // First cycle of a fetch: launch the request for byte 0.
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc + {60'd0, idx};
                end else if (mem_ack) begin
                    if (mem_err) begin
                        state_d      = DONE;
                        mem_req_d    = 1'b0;
                        out_valid_d  = 1'b1;
                        imem_error_d = 1'b1;
                        halted_d     = 1'b1;
                        valP_d       = pc;
                    end else begin
                        idx_d = idx + 4'd1;
                        if (state == BYTE0) begin
                            icode_d       = mem_data[7:4];
                            ifun_d        = mem_data[3:0];
                            len_d         = instr_len(mem_data[7:4]);
                            instr_valid_d = (mem_data[7:4] <= 4'hB);
                            if (len_d == 4'd1)      last_byte = 1'b1;
                            else if (len_d == 4'd9) state_d   = CONST;
                            else                    state_d   = REGS;
                        end else if (state == REGS) begin
                            rA_d = mem_data[7:4];
                            rB_d = mem_data[3:0];
                            if (len == 4'd10) state_d   = CONST;
                            else              last_byte = 1'b1;
                        end else begin
                            // Little-endian: shifting each byte in from the top
                            // leaves the first byte in valC[7:0] after eight.
                            valC_d = {mem_data, valC[63:8]};
                            if (idx == len - 4'd1) last_byte = 1'b1;
                        end

                        if (last_byte) begin
                            state_d     = DONE;
                            mem_req_d   = 1'b0;
                            out_valid_d = 1'b1;
                            valP_d      = pc + {60'd0, len_d};
                            if (icode_d == 4'h0) halted_d = 1'b1;
`ifdef FETCH_INVALID_TRAP_EN
                            if (icode_d >= 4'hC) halted_d = 1'b1;
`endif
                        end else begin
                            mem_addr_d = pc + {60'd0, idx_d};
                        end
                    end
                end
            end

            DONE: begin
                if (pc_load) begin
                    pc_d        = next_pc;
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= 4'd0;
            len         <= 4'd1;
            pc          <= RESET_PC;
            mem_req     <= 1'b0;
            mem_addr    <= 64'h0;
            out_valid   <= 1'b0;
            icode       <= 4'h0;
            ifun        <= 4'h0;
            rA          <= 4'hF;
            rB          <= 4'hF;
            valC        <= 64'h0;
            valP        <= 64'h0;
            imem_error  <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            len         <= len_d;
            pc          <= pc_d;
            mem_req     <= mem_req_d;
            mem_addr    <= mem_addr_d;
            out_valid   <= out_valid_d;
            icode       <= icode_d;
            ifun        <= ifun_d;
            rA          <= rA_d;
            rB          <= rB_d;
            valC        <= valC_d;
            valP        <= valP_d;
            imem_error  <= imem_error_d;
            instr_valid <= instr_valid_d;
            halted      <= halted_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// Testbench for fetch_unit: directed instructions from a byte memory model,
// expected responses queued at issue time and compared by a monitor when
// out_valid rises.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, start, pc_load;
    logic [63:0] next_pc;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_ack, mem_err;
    logic        out_valid;
    logic [63:0] pc;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic        imem_error, instr_valid, halted;

    fetch_unit dut (
        .clk(clk), .rst(rst), .start(start), .pc_load(pc_load), .next_pc(next_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ack(mem_ack), .mem_err(mem_err), .out_valid(out_valid), .pc(pc),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
        .imem_error(imem_error), .instr_valid(instr_valid), .halted(halted)
    );

    always #5 clk = ~clk;

`ifdef FETCH_INVALID_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic        ierr, iv, hlt;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte memory (low 12 address bits) with optional stall and fault.
    logic [7:0]  mem [0:4095];
    logic [63:0] stall_addr = '1;
    int          stall_left = 0;
    logic        err_en = 1'b0;
    logic [63:0] err_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input string n, input logic [3:0] ic, input logic [3:0] fn,
                                input logic [3:0] ra, input logic [3:0] rb,
                                input logic [63:0] vc, input logic [63:0] vp,
                                input logic ie, input logic iv, input logic h);
        exp_t e;
        e.name = n; e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb;
        e.valc = vc; e.valp = vp; e.ierr = ie; e.iv = iv; e.hlt = h; e.cyc = 0;
        return e;
    endfunction

    task automatic put_bytes(input logic [63:0] base, input int n, input logic [79:0] bytes);
        logic [63:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 64'(i);
            mem[a[11:0]] = bytes[79 - 8*i -: 8];
        end
    endtask

    // Start a fetch; lat is the expected number of edges from the start edge
    // to the edge where out_valid rises.
    task automatic issue(input exp_t e, input int lat);
        @(posedge clk); #1;
        start = 1'b1;
        e.cyc = cyc + 1 + lat;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string n);
        int k;
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got out_valid=0 expected 1 within 40 cycles", n);
        end
    endtask

    task automatic load_pc(input logic [63:0] v);
        @(posedge clk); #1;
        pc_load = 1'b1;
        next_pc = v;
        @(posedge clk); #1;
        pc_load = 1'b0;
        check("pc_load_pc", pc, v);
        check("pc_load_out_valid", 64'(out_valid), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Memory responder: answers the registered request shortly after each edge.
    initial begin
        mem_ack = 1'b0;
        mem_data = 8'h00;
        mem_err = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (mem_req && stall_left > 0 && mem_addr == stall_addr) begin
                mem_ack = 1'b0;
                stall_left--;
            end else if (mem_req) begin
                mem_ack  = 1'b1;
                mem_data = mem[mem_addr[11:0]];
                mem_err  = err_en && (mem_addr == err_addr);
            end else begin
                mem_ack = 1'b0;
                mem_err = 1'b0;
            end
        end
    end

    // Monitor: compare each new out_valid against the oldest expectation.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (out_valid && !prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
                    check({e.name, "_icode"}, 64'(icode), 64'(e.icode));
                    check({e.name, "_ifun"}, 64'(ifun), 64'(e.ifun));
                    check({e.name, "_rA"}, 64'(rA), 64'(e.ra));
                    check({e.name, "_rB"}, 64'(rB), 64'(e.rb));
                    check({e.name, "_valC"}, valC, e.valc);
                    check({e.name, "_valP"}, valP, e.valp);
                    check({e.name, "_imem_error"}, 64'(imem_error), 64'(e.ierr));
                    check({e.name, "_instr_valid"}, 64'(instr_valid), 64'(e.iv));
                    check({e.name, "_halted"}, 64'(halted), 64'(e.hlt));
                end
            end
            prev = out_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        rst = 1'b1; start = 1'b0; pc_load = 1'b0; next_pc = 64'h0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        check("rst_pc", pc, 64'h0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", mem_addr, 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_icode", 64'(icode), 64'h0);
        check("rst_rA", 64'(rA), 64'hF);
        check("rst_rB", 64'(rB), 64'hF);
        check("rst_valC", valC, 64'h0);
        check("rst_valP", valP, 64'h0);
        check("rst_imem_error", 64'(imem_error), 64'd0);
        check("rst_instr_valid", 64'(instr_valid), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);

        // nop at 0
        put_bytes(64'h0, 1, 80'h10 << 72);
        issue(mk("nop", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 1'b0, 1'b1, 1'b0), 2);
        wait_done("nop");

        // irmovq at 0x100
        load_pc(64'h100);
        put_bytes(64'h100, 10, 80'h30F3_0807_0605_0403_0201);
        issue(mk("irmovq", 4'h3, 4'h0, 4'hF, 4'h3, 64'h0102030405060708, 64'h10A,
                 1'b0, 1'b1, 1'b0), 11);
        wait_done("irmovq");

        // call at 0x200 with two wait cycles on byte 3 and a pc_load mid-fetch
        load_pc(64'h200);
        put_bytes(64'h200, 9, {72'h80_EFBEADDE_00000000, 8'h00});
        stall_addr = 64'h203;
        stall_left = 2;
        issue(mk("call", 4'h8, 4'h0, 4'hF, 4'hF, 64'hDEADBEEF, 64'h209, 1'b0, 1'b1, 1'b0), 12);
        pc_load = 1'b1;
        next_pc = 64'hBAD;
        @(posedge clk); #1;
        @(posedge clk); #1;
        pc_load = 1'b0;
        wait_done("call");
        check("call_pc_unchanged", pc, 64'h200);
        stall_left = 0;

        // OPq at the top of the address space: address and valP wrap
        load_pc(64'hFFFF_FFFF_FFFF_FFFF);
        put_bytes(64'hFFFF_FFFF_FFFF_FFFF, 2, {16'h6512, 64'h0});
        issue(mk("opq_wrap", 4'h6, 4'h5, 4'h1, 4'h2, 64'h0, 64'h1, 1'b0, 1'b1, 1'b0), 3);
        wait_done("opq_wrap");

        // fault on the second byte of 60 12
        load_pc(64'h300);
        put_bytes(64'h300, 2, {16'h6012, 64'h0});
        err_en = 1'b1;
        err_addr = 64'h301;
        issue(mk("mem_err", 4'h6, 4'h0, 4'hF, 4'hF, 64'h0, 64'h300, 1'b1, 1'b1, 1'b1), 3);
        wait_done("mem_err");
        err_en = 1'b0;
        do_reset();
        check("err_rst_halted", 64'(halted), 64'd0);

        // illegal icode C
        put_bytes(64'h0, 1, 80'hC0 << 72);
        issue(mk("invalid", 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 1'b0, 1'b0, TRAP), 2);
        wait_done("invalid");
        do_reset();

        // halt: sticky, start ignored, pc_load still honoured
        put_bytes(64'h0, 1, 80'h00);
        issue(mk("halt", 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 1'b0, 1'b1, 1'b1), 2);
        wait_done("halt");
        load_pc(64'h40);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen |= mem_req;
            @(posedge clk); #1;
        end
        check("halted_no_mem_req", 64'(seen), 64'd0);
        check("halted_pc", pc, 64'h40);
        check("halted_sticky", 64'(halted), 64'd1);
        do_reset();
        check("halt_rst_halted", 64'(halted), 64'd0);
        check("halt_rst_pc", pc, 64'h0);

        // reset in the middle of a fetch discards it
        put_bytes(64'h0, 10, 80'h30F3_0807_0605_0403_0201);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midfetch_req_before_rst", 64'(mem_req), 64'd1);
        do_reset();
        check("midfetch_rst_mem_req", 64'(mem_req), 64'd0);
        check("midfetch_rst_out_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
        end
        check("final_out_valid", 64'(out_valid), 64'd0);
        check("final_queue_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Fetch stage of the SEQ Y86-64 datapath. It holds the architectural PC and reads one instruction byte per handshake from a byte-wide instruction memory. It splits the instruction into icode/ifun/rA/rB/valC and computes valP for decode, execute and pc_update. The next PC is loaded from pc_update's `updated_pc` output through `pc_load`/`next_pc`.

## Interface
Parameters:
- `RESET_PC`, default 64'h0: PC value after reset.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: begin fetching at the current PC; honoured only in IDLE.
- `pc_load` in 1: load `next_pc` into PC; honoured in IDLE and DONE.
- `next_pc` in 64: the next PC, driven from pc_update `updated_pc`.
- `mem_req` out 1: byte read request.
- `mem_addr` out 64: byte address, stable while `mem_req` is high.
- `mem_data` in 8: read byte, valid when `mem_ack` is high.
- `mem_ack` in 1: byte accepted on this edge.
- `mem_err` in 1: qualified by `mem_ack`; the address is out of range.
- `out_valid` out 1: instruction fields are valid.
- `pc` out 64: current PC.
- `icode`, `ifun`, `rA`, `rB` out 4 each: decoded fields.
- `valC` out 64: constant word.
- `valP` out 64: fall-through address.
- `imem_error` out 1: memory fault on this fetch.
- `instr_valid` out 1: icode is legal.
- `halted` out 1: sticky halt/fault flag.

## Operation
- States: IDLE, BYTE0, REGS, CONST, DONE.
- IDLE + `start` (and not `halted`): go to BYTE0 and set the byte pointer to PC. If `pc_load` is high in the same cycle, PC takes `next_pc` and the fetch uses `next_pc`.
- `mem_req`=1 in BYTE0/REGS/CONST only. `mem_addr` = PC + byte index, wrapping modulo 2^64.
- BYTE0 on ack: capture icode = `mem_data[7:4]` and ifun = `mem_data[3:0]`. The icode sets the instruction length L:
  - L=1: 0 (halt), 1 (nop), 9 (ret); go to DONE.
  - L=2: 2 (rrmovq/cmovXX), 6 (OPq), A (pushq), B (popq); go to REGS.
  - L=10: 3 (irmovq), 4 (rmmovq), 5 (mrmovq); go to REGS.
  - L=9: 7 (jXX), 8 (call); go to CONST.
  - icode C–F: handled per Configuration.
- REGS on ack: capture rA = `mem_data[7:4]` and rB = `mem_data[3:0]`. Go to CONST if L=10, else DONE.
- CONST: 8 acked bytes, little-endian; the first byte is `valC[7:0]`. Go to DONE after the 8th ack.
- Fields not present in the instruction read as rA=rB=4'hF and valC=0.
- valP = PC + L, computed modulo 2^64, valid in DONE.
- DONE: `out_valid`=1 and fields are held.
  - `pc_load` loads PC, clears `out_valid`, and returns to IDLE.
  - `start` in DONE is ignored.
- `mem_err` with `mem_ack` in any fetch state: set `imem_error`=1 and `halted`=1, go to DONE immediately, and set valP = PC.
- icode 0 reaching DONE sets `halted`=1.
- `halted` is sticky until `rst`: `start` is ignored, while `pc_load` still updates PC.
- No ack: the state holds and `mem_req`/`mem_addr` stay unchanged.

## Timing
- Reset values: PC=`RESET_PC`, state IDLE, `mem_req`=0, `mem_addr`=0, `out_valid`=0, icode=ifun=0, rA=rB=4'hF, valC=0, valP=0, `imem_error`=0, `instr_valid`=0, `halted`=0.
- All outputs are registered.
- With `start` at edge T and `mem_ack` always high: `mem_req` is high for L cycles from T+1, and `out_valid` rises at edge T+L+1. Examples: nop at T+2, OPq at T+3, call at T+10, irmovq at T+11.
- Each wait cycle (ack low) adds exactly one cycle.
- `rst` during a fetch: at the next edge the state returns to IDLE and `mem_req` drops. A partially captured instruction is discarded.
- `pc_load` in BYTE0/REGS/CONST is ignored and PC is unchanged.

## Configuration
- `FETCH_INVALID_TRAP_EN` defined:
  - icode C–F gives L=1, `instr_valid`=0, `halted`=1, and goes to DONE.
- `FETCH_INVALID_TRAP_EN` not defined:
  - icode C–F gives L=1 and `instr_valid`=0.
  - `halted` is not set, so execution may continue (treated as a nop).
- In both builds `instr_valid`=1 for icode 0–B.

## Test plan
- Reset, then `start` with memory {0x10} at 0: `out_valid` at T+2 with icode=1, valP=1, rA=rB=F, `halted`=0.
- PC=0x100, bytes 30 F3 08 07 06 05 04 03 02 01, always ack: `out_valid` at T+11 with icode=3, rB=3, valC=0x0102030405060708, valP=0x10A.
- call 80 EF BE AD DE 00 00 00 00 with ack low for 2 cycles on byte 3: `out_valid` at T+12 with valC=0xDEADBEEF, valP=PC+9.
- halt 0x00: `halted`=1. A later `pc_load` of 0x40 updates PC, but `start` causes no `mem_req`. `rst` then clears `halted`.
- `mem_err` on byte 2 of 60 12: `imem_error`=1, `halted`=1, valP=PC. Byte 0xC0 gives `instr_valid`=0, and `halted`=1 only when `FETCH_INVALID_TRAP_EN` is defined.
